// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the burst RAM controller: state encoding and default sizes.
package ram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RAM_DEPTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_END  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/ram_burst_counter.sv
// Burst address/beat tracker: loadable word address that wraps modulo RAM_Depth,
// beat counter against the latched length, and a flag marking the final beat.
module ram_burst_counter
  import ram_ctrl_pkg::*;
#(
  parameter  int RAM_Depth = DEF_RAM_DEPTH,
  localparam int AW        = $clog2(RAM_Depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [AW-1:0] load_len,
  input  logic          adv,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] addr_nxt,
  output logic          last
);

  logic [AW-1:0] len_q;
  logic [AW-1:0] beat_q;

  // Wrap explicitly so non-power-of-two depths also return to word 0.
  assign addr_nxt = (addr == AW'(RAM_Depth - 1)) ? '0 : addr + AW'(1);
  assign last     = (beat_q == len_q);

  // Address, length and beat registers; load wins over advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else if (load) begin
      addr   <= load_addr;
      len_q  <= load_len;
      beat_q <= '0;
    end else if (adv) begin
      addr   <= addr_nxt;
      beat_q <= beat_q + AW'(1);
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst command front-end for a registered-read single-port RAM. Write bursts
// stream one beat per cycle; read bursts issue one strobe and return one beat
// every two cycles because the RAM output is registered.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter  int Data_Width = DEF_DATA_WIDTH,
  parameter  int RAM_Depth  = DEF_RAM_DEPTH,
  localparam int AW         = $clog2(RAM_Depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [AW-1:0]         cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [Data_Width-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [Data_Width-1:0] rdata,
  output logic                  mem_cs,
  output logic                  mem_oe,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_addr,
  output logic [Data_Width-1:0] mem_wdata,
  input  logic [Data_Width-1:0] mem_rdata,
  output logic                  busy
);

  state_t state, state_nxt;

  logic                  cnt_load, cnt_adv, cnt_last;
  logic [AW-1:0]         cnt_addr, cnt_addr_nxt;
  logic                  cs_nxt, oe_nxt, wr_nxt;
  logic [AW-1:0]         addr_nxt;
  logic [Data_Width-1:0] wdata_nxt;

  ram_burst_counter #(
    .RAM_Depth (RAM_Depth)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .adv       (cnt_adv),
    .addr      (cnt_addr),
    .addr_nxt  (cnt_addr_nxt),
    .last      (cnt_last)
  );

  // Handshake signals are pure state decodes so they drop the cycle the state leaves.
  assign cmd_ready   = (state == ST_IDLE);
  assign wdata_ready = (state == ST_WR);
  assign rdata_valid = (state == ST_RD_RESP);
  assign rdata       = rdata_valid ? mem_rdata : '0;
  assign busy        = (state != ST_IDLE);

  // Next-state and strobe decode; strobes default low so every pulse is one cycle.
  always_comb begin
    state_nxt = state;
    cs_nxt    = 1'b0;
    oe_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    cnt_load  = 1'b0;
    cnt_adv   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_load = 1'b1;
          if (cmd_write) begin
            state_nxt = ST_WR;
          end else begin
            cs_nxt    = 1'b1;
            oe_nxt    = 1'b1;
            addr_nxt  = cmd_addr;
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_WR: begin
        if (wdata_valid) begin
          cs_nxt    = 1'b1;
          wr_nxt    = 1'b1;
          addr_nxt  = cnt_addr;
          wdata_nxt = wdata;
          cnt_adv   = 1'b1;
          if (cnt_last) state_nxt = ST_WR_END;
        end
      end
      // Lets the RAM sample the final write strobe before a new command can start.
      ST_WR_END:  state_nxt = ST_IDLE;
      ST_RD_WAIT: state_nxt = ST_RD_RESP;
      ST_RD_RESP: begin
        if (rdata_ready) begin
          if (cnt_last) begin
            state_nxt = ST_IDLE;
          end else begin
            cs_nxt    = 1'b1;
            oe_nxt    = 1'b1;
            addr_nxt  = cnt_addr_nxt;
            cnt_adv   = 1'b1;
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered RAM-side outputs; reset clears everything so no strobe follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_cs    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      mem_cs    <= cs_nxt;
      mem_oe    <= oe_nxt;
      mem_wr_en <= wr_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a registered-read RAM model.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid, rdata_ready;
  logic [7:0] rdata;
  logic       mem_cs, mem_oe, mem_wr_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  int cs_cnt = 0, wr_cnt = 0, oe_cnt = 0, accept_cnt = 0;
  logic [3:0] wr_addrs[$];
  logic [3:0] rd_addrs[$];
  logic [7:0] got[$];
  logic [7:0] ram [16];

  always #5 clk = ~clk;

  ram_burst_ctrl #(.Data_Width(8), .RAM_Depth(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Registered-read RAM: write on cs&wr_en, read data appears after cs&oe edge and holds.
  always @(posedge clk) begin
    if (mem_cs && mem_wr_en) ram[mem_addr] <= mem_wdata;
    else if (mem_cs && mem_oe) mem_rdata <= ram[mem_addr];
  end

  // Strobe and handshake monitor.
  always @(posedge clk) begin
    if (mem_cs) begin
      cs_cnt <= cs_cnt + 1;
      if (mem_wr_en) begin
        wr_cnt <= wr_cnt + 1;
        wr_addrs.push_back(mem_addr);
      end else if (mem_oe) begin
        rd_addrs.push_back(mem_addr);
      end
    end
    if (mem_oe) oe_cnt <= oe_cnt + 1;
    if (cmd_valid && cmd_ready) accept_cnt <= accept_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] l,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3, input bit gaps);
    logic [7:0] d [4];
    int guard;
    d = '{d0, d1, d2, d3};
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 0;
    for (int i = 0; i <= int'(l); i++) begin
      wdata_valid = 1; wdata = d[i];
      tick();
      if (gaps) begin
        wdata_valid = 0;
        tick();
      end
    end
    wdata_valid = 0;
    guard = 0;
    while (!cmd_ready && guard < 10) begin
      tick();
      guard++;
    end
    check("wr_back_to_idle", cmd_ready, 1);
  endtask

  task automatic collect(input int n, input int sb, input int sn);
    int beat, stalled, guard, cs0;
    logic [7:0] held;
    beat = 0; stalled = 0; guard = 0; cs0 = 0; held = 0;
    got.delete();
    while (beat < n && guard < 200) begin
      guard++;
      if (rdata_valid) begin
        if (beat == sb && stalled < sn) begin
          if (stalled == 0) begin
            held = rdata;
            cs0  = cs_cnt;
          end else begin
            check("rd_stall_hold", rdata, held);
          end
          rdata_ready = 0;
          stalled++;
        end else begin
          if (beat == sb && sn > 0) begin
            check("rd_stall_release", rdata, held);
            check("rd_stall_no_cs", cs_cnt, cs0);
          end
          rdata_ready = 1;
          got.push_back(rdata);
          beat++;
        end
      end else begin
        rdata_ready = 0;
      end
      tick();
    end
    rdata_ready = 0;
    check("rd_beats", beat, n);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int sb, input int sn);
    cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 0;
    collect(int'(l) + 1, sb, sn);
    check("rd_back_to_idle", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0, wr0, oe0, acc0;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wdata_valid = 0; wdata = 0; rdata_ready = 0;
    tick(); tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_wdata_ready", wdata_ready, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 0;
    tick();

    // Single write addr 3, len 0, data A5
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3; cmd_len = 0;
    tick();
    cmd_valid = 0;
    check("w1_wdata_ready", wdata_ready, 1);
    check("w1_cmd_ready", cmd_ready, 0);
    wdata_valid = 1; wdata = 8'hA5;
    tick();
    wdata_valid = 0;
    check("w1_cs", mem_cs, 1);
    check("w1_wr_en", mem_wr_en, 1);
    check("w1_addr", mem_addr, 3);
    check("w1_wdata", mem_wdata, 8'hA5);
    check("w1_wr_end_ready", wdata_ready, 0);
    tick();
    check("w1_idle", cmd_ready, 1);
    check("w1_cs_low", mem_cs, 0);
    check("w1_ram", ram[3], 8'hA5);

    // Single read addr 3: valid in 2nd cycle after accept
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3; cmd_len = 0;
    tick();
    cmd_valid = 0; rdata_ready = 1;
    check("r1_c1_valid", rdata_valid, 0);
    check("r1_c1_cs", mem_cs, 1);
    check("r1_c1_oe", mem_oe, 1);
    check("r1_c1_wr_en", mem_wr_en, 0);
    check("r1_c1_addr", mem_addr, 3);
    tick();
    check("r1_c2_valid", rdata_valid, 1);
    check("r1_c2_data", rdata, 8'hA5);
    check("r1_c2_cs", mem_cs, 0);
    tick();
    rdata_ready = 0;
    check("r1_idle", cmd_ready, 1);
    check("r1_valid_low", rdata_valid, 0);

    // Wrapping 4-beat write at 14 then read back
    wr_addrs.delete();
    do_write(4'd14, 4'd3, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    check("w4_n_addrs", wr_addrs.size(), 4);
    check("w4_addr0", wr_addrs[0], 14);
    check("w4_addr1", wr_addrs[1], 15);
    check("w4_addr2", wr_addrs[2], 0);
    check("w4_addr3", wr_addrs[3], 1);
    rd_addrs.delete();
    do_read(4'd14, 4'd3, -1, 0);
    check("r4_d0", got[0], 1);
    check("r4_d1", got[1], 2);
    check("r4_d2", got[2], 3);
    check("r4_d3", got[3], 4);
    check("r4_n_addrs", rd_addrs.size(), 4);
    check("r4_addr2", rd_addrs[2], 0);
    check("r4_addr3", rd_addrs[3], 1);

    // Read backpressure: beat 2 stalled 5 cycles
    do_read(4'd14, 4'd3, 1, 5);
    check("bp_d0", got[0], 1);
    check("bp_d1", got[1], 2);
    check("bp_d2", got[2], 3);
    check("bp_d3", got[3], 4);

    // Write with gaps: one strobe per beat, no oe
    cs0 = cs_cnt; wr0 = wr_cnt; oe0 = oe_cnt;
    do_write(4'd5, 4'd3, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    check("gap_cs_pulses", cs_cnt - cs0, 4);
    check("gap_wr_pulses", wr_cnt - wr0, 4);
    check("gap_oe_pulses", oe_cnt - oe0, 0);
    do_read(4'd5, 4'd3, -1, 0);
    check("gap_d0", got[0], 8'h10);
    check("gap_d3", got[3], 8'h40);

    // Reset during beat 2 of a 4-beat read
    cmd_valid = 1; cmd_write = 0; cmd_addr = 14; cmd_len = 3;
    tick();
    cmd_valid = 0;
    tick();
    check("rr_beat1_valid", rdata_valid, 1);
    rdata_ready = 1;
    tick();
    rdata_ready = 0;
    tick();
    check("rr_beat2_valid", rdata_valid, 1);
    rst = 1;
    tick();
    cs0 = cs_cnt;
    check("rr_cmd_ready", cmd_ready, 1);
    check("rr_busy", busy, 0);
    check("rr_cs", mem_cs, 0);
    check("rr_oe", mem_oe, 0);
    check("rr_wr_en", mem_wr_en, 0);
    check("rr_addr", mem_addr, 0);
    check("rr_wdata", mem_wdata, 0);
    check("rr_rdata_valid", rdata_valid, 0);
    check("rr_rdata", rdata, 0);
    check("rr_wdata_ready", wdata_ready, 0);
    rst = 0;
    tick(); tick(); tick();
    check("rr_no_strobes", cs_cnt - cs0, 0);

    // cmd_valid held across a burst: accepted exactly once after IDLE
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8; cmd_len = 1;
    tick();
    cmd_write = 0;
    wdata_valid = 1; wdata = 8'h77;
    check("hold_ready_wr0", cmd_ready, 0);
    tick();
    wdata = 8'h88;
    check("hold_ready_wr1", cmd_ready, 0);
    tick();
    wdata_valid = 0;
    check("hold_ready_wr_end", cmd_ready, 0);
    acc0 = accept_cnt;
    tick();
    check("hold_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    check("hold_accept_once", accept_cnt - acc0, 1);
    check("hold_busy", busy, 1);
    collect(2, -1, 0);
    check("hold_d0", got[0], 8'h77);
    check("hold_d1", got[1], 8'h88);
    check("hold_accept_total", accept_cnt - acc0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter Data_Width, default 8, RAM word width.
REQ-002 SHALL have parameter RAM_Depth, default 16, number of RAM words; AW = $clog2(RAM_Depth).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted this cycle.
REQ-007 SHALL have port cmd_write, input, 1, 1 = burst write, 0 = burst read.
REQ-008 SHALL have port cmd_addr, input, AW, first word address.
REQ-009 SHALL have port cmd_len, input, AW, beats minus one (0..RAM_Depth-1).
REQ-010 SHALL have ports wdata_valid, input, 1 / wdata_ready, output, 1 / wdata, input, Data_Width: write-beat stream.
REQ-011 SHALL have ports rdata_valid, output, 1 / rdata_ready, input, 1 / rdata, output, Data_Width: read-beat stream.
REQ-012 SHALL have ports mem_cs, mem_oe, mem_wr_en, output, 1 each: RAM strobes.
REQ-013 SHALL have ports mem_addr, output, AW / mem_wdata, output, Data_Width / mem_rdata, input, Data_Width: RAM address and data.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL drive the RAM side of a registered-read RAM: a write occurs at the edge sampling mem_cs=1, mem_wr_en=1; read data appears on mem_rdata after the edge sampling mem_cs=1, mem_wr_en=0, mem_oe=1, and holds until the next read.
REQ-016 SHALL register mem_cs, mem_oe, mem_wr_en, mem_addr and mem_wdata; each strobe pulse SHALL last exactly one cycle.
REQ-017 SHALL implement states IDLE, WR, WR_END, RD_WAIT and RD_RESP.
REQ-018 IDLE: cmd_ready=1; on cmd_valid, latch addr and len; go to WR if cmd_write, else register a read strobe at cmd_addr and go to RD_WAIT.
REQ-019 WR: wdata_ready=1; each wdata handshake registers a write strobe at the current address with mem_wdata=wdata, then increments the address; one beat per cycle back-to-back.
REQ-020 WR, last beat (beat count = len): go to WR_END; WR_END lasts one cycle so the final strobe is sampled by the RAM, then IDLE.
REQ-021 RD_WAIT: one cycle with the strobe visible; go to RD_RESP with strobes low.
REQ-022 RD_RESP: rdata_valid=1 and rdata=mem_rdata; hold the beat stable while rdata_ready=0.
REQ-023 RD_RESP handshake, not last: register the next read strobe at address+1 and go to RD_WAIT; throughput is one beat per 2 cycles.
REQ-024 RD_RESP handshake, last: go to IDLE.
REQ-025 SHALL give read latency of rdata_valid high in the second cycle after the cmd-accept edge.
REQ-026 SHALL wrap the address from RAM_Depth-1 to 0 and SHALL NOT flag wrap as an error.
REQ-027 SHALL hold cmd_ready, wdata_ready and rdata_valid low outside IDLE, WR and RD_RESP respectively; a cmd_valid offered while busy SHALL wait.
REQ-028 A cmd_len of 0 SHALL produce exactly one beat.

Reset
REQ-029 When rst is sampled high, SHALL set state IDLE and all outputs to 0 (cmd_ready=1 after reset), with counters and latched addr and len cleared.
REQ-030 Reset mid-burst SHALL abandon remaining beats; a strobe already registered before the reset edge completes in the RAM, and no strobe is issued after it.

Structure
REQ-031 SHALL place the state encoding and the default Data_Width and RAM_Depth in shared package ram_ctrl_pkg.
REQ-032 SHALL instantiate one sub-module, ram_burst_counter: loadable address (mod RAM_Depth) plus beat counter, with a last flag.

Verification
REQ-033 Bench SHALL cover single write then read: write addr 3, len 0, data 8'hA5; then read addr 3 -> rdata=8'hA5, rdata_valid in the 2nd cycle after accept.
REQ-034 Bench SHALL cover a 4-beat write at addr 14 with data 1,2,3,4, then a read of addr 14, len 3 -> 1,2,3,4; addresses 14, 15, 0, 1 (wrap).
REQ-035 Bench SHALL cover read backpressure: rdata_ready low for 5 cycles on beat 2 -> rdata stable, no new mem_cs pulse, order preserved.
REQ-036 Bench SHALL cover write gaps: wdata_valid toggling 1,0,1,0 -> exactly one mem_cs/mem_wr_en pulse per accepted beat, mem_oe stays 0.
REQ-037 Bench SHALL cover reset during beat 2 of a 4-beat read -> next cycle state IDLE, all outputs 0 except cmd_ready=1, no further strobes.
REQ-038 Bench SHALL cover cmd_valid held during a burst -> cmd_ready=0 until IDLE, then the command is accepted exactly once.
